alu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single combinational ALU between N_REQ requesters, for example the execute stage and the address-generation/CSR path.
- Each requester presents operands and an ALU control code over a valid/ready request channel.
- Each requester receives its result over its own valid/ready response channel.
- Only one operation is in flight at a time; operands and result are registered around the ALU.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/rr_arb.sv | 39 +++
 rtl/alu_arb.sv | 135 +++++++++++++
 tb/tb_alu_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing logic: control codes, sequencer states and
// default datapath widths.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CTL_W  = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin grant: first requester at or above ptr_i, wrapping to the
// lowest requester when nothing at or above the pointer is asking.
module rr_arb
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_gnt_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;

        // Lowest requester overall is the wrap-around candidate.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_idx_o = IDX_W'(i);
                any_gnt_o = 1'b1;
            end
        end

        // Lowest requester at or above the pointer takes precedence.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(ptr_i))) begin
                gnt_idx_o = IDX_W'(i);
            end
        end

        gnt_o[gnt_idx_o] = any_gnt_o;
    end

endmodule

// File: rtl/alu_arb.sv
// Shares one external combinational ALU between N_REQ requesters: round-robin accept,
// one registered operation in flight, per-requester valid/ready response.
module alu_arb
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTL_W  = DEF_CTL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*DATA_W-1:0] req_a_i,
    input  logic [N_REQ*DATA_W-1:0] req_b_i,
    input  logic [N_REQ*CTL_W-1:0]  req_ctl_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    input  logic [N_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic [DATA_W-1:0]       alu_a_o,
    output logic [DATA_W-1:0]       alu_b_o,
    output logic [CTL_W-1:0]        aluctl_ctl_o,
    input  logic [DATA_W-1:0]       alu_out_i
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CTL_W-1:0]  ctl_q, ctl_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              any_gnt;

    rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        ctl_d    = ctl_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                // The granted requester is the only one seeing ready, so a grant is a handshake.
                if (any_gnt) begin
                    a_d     = req_a_i[gnt_idx*DATA_W +: DATA_W];
                    b_d     = req_b_i[gnt_idx*DATA_W +: DATA_W];
                    ctl_d   = req_ctl_i[gnt_idx*CTL_W +: CTL_W];
                    owner_d = gnt_idx;
                    if (int'(gnt_idx) == int'(N_REQ) - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d = alu_out_i;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (!rst) begin
            if (state_q == StIdle) begin
                req_ready_o = gnt;
            end
            if (state_q == StResp) begin
                rsp_valid_o[owner_q] = 1'b1;
            end
        end
    end

    // ALU inputs come straight from the operand registers so they only move on accept.
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign aluctl_ctl_o = ctl_q;
    assign rsp_data_o   = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            owner_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctl_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctl_q    <= ctl_d;
            result_q <= result_d;
        end
    end

    a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_o));
    a_rsp_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid_o));
    a_no_overlap   : assert property (@(posedge clk) disable iff (rst)
                                      !((|req_ready_o) && (|rsp_valid_o)));

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: directed vectors and sequences, then randomized traffic against a
// transaction-level round-robin model. The ALU itself is modelled here.
module tb_alu_arb;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [N*4-1:0] req_ctl;
    logic [W-1:0]   rsp_data, alu_a, alu_b, alu_out;
    logic [3:0]     alu_ctl;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          idx;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default:  return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_ctl);

    alu_arb #(
        .N_REQ  (N),
        .DATA_W (W),
        .CTL_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ctl_i    (req_ctl),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .aluctl_ctl_o (alu_ctl),
        .alu_out_i    (alu_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_ctl[i*4 +: 4]  = c;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic run_single(input int i, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input string nm);
        set_req(i, c, a, b);
        rsp_ready = '1;
        @(negedge clk);
        check({nm, " ready"}, 64'(req_ready), 64'(1) << i);
        tick();
        req_valid[i] = 1'b0;
        @(negedge clk);
        check({nm, " exec no rsp"}, 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        check({nm, " rsp_valid"}, 64'(rsp_valid), 64'(1) << i);
        check({nm, " rsp_data"}, 64'(rsp_data), 64'(exp));
        tick();
        @(negedge clk);
        check({nm, " rsp done"}, 64'(rsp_valid), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          acc_idx [6];
        int          acc_cyc [6];
        int          n_acc;
        int          m_ptr, m_owner, m_acc, g;
        bit          m_busy;
        logic [31:0] m_exp;
        logic [N-1:0] acc;

        vecs[0]  = '{0, ALU_ADD,  32'd5,          32'd7,          32'd12,         "add"};
        vecs[1]  = '{1, ALU_SUB,  32'd10,         32'd3,          32'd7,          "sub"};
        vecs[2]  = '{0, ALU_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  "sra"};
        vecs[3]  = '{1, ALU_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,          "sltu"};
        vecs[4]  = '{0, ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          "slt"};
        vecs[5]  = '{1, ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          "sltu_neg"};
        vecs[6]  = '{0, ALU_XOR,  32'hFF,         32'h0F,         32'hF0,         "xor"};
        vecs[7]  = '{1, ALU_SLL,  32'd1,          32'd31,         32'h8000_0000,  "sll"};
        vecs[8]  = '{0, ALU_SRL,  32'h8000_0000,  32'd31,         32'd1,          "srl"};
        vecs[9]  = '{1, ALU_AND,  32'hF0F0,       32'hFF00,       32'hF000,       "and"};
        vecs[10] = '{0, ALU_OR,   32'hF0,         32'h0F,         32'hFF,         "or"};

        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        req_ctl = '0;

        // Reset state, with requests present.
        @(negedge clk);
        check("reset ready", 64'(req_ready), 64'd0);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset alu_a", 64'(alu_a), 64'd0);
        check("reset alu_b", 64'(alu_b), 64'd0);
        check("reset alu_ctl", 64'(alu_ctl), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        tick();
        rst = 1'b0;
        req_valid = '0;

        // Single op, then the pointer must favour requester 1.
        run_single(0, ALU_ADD, 32'd5, 32'd7, 32'd12, "single add");
        set_req(0, ALU_AND, 32'hF, 32'h3);
        set_req(1, ALU_OR, 32'h10, 32'h1);
        @(negedge clk);
        check("ptr after req0", 64'(req_ready), 64'b10);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("ptr op rsp_valid", 64'(rsp_valid), 64'b10);
        check("ptr op rsp_data", 64'(rsp_data), 64'h11);
        tick();

        for (int v = 0; v < 11; v++) begin
            run_single(vecs[v].idx, vecs[v].ctl, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].name);
        end

        // Simultaneous requests from ptr=0.
        do_reset();
        rsp_ready = '1;
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        set_req(1, ALU_SRA, 32'h8000_0000, 32'd4);
        @(negedge clk);
        check("sim grant0", 64'(req_ready), 64'b01);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("sim exec ready", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        check("sim rsp0 valid", 64'(rsp_valid), 64'b01);
        check("sim rsp0 data", 64'(rsp_data), 64'd7);
        tick();
        @(negedge clk);
        check("sim grant1", 64'(req_ready), 64'b10);
        tick();
        req_valid[1] = 1'b0;
        tick();
        @(negedge clk);
        check("sim rsp1 valid", 64'(rsp_valid), 64'b10);
        check("sim rsp1 data", 64'(rsp_data), 64'hF800_0000);
        tick();

        // Back-pressure on requester 1; requester 0 waits meanwhile.
        rsp_ready = 2'b01;
        set_req(1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        check("bp grant1", 64'(req_ready), 64'b10);
        tick();
        req_valid[1] = 1'b0;
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        @(negedge clk);
        check("bp exec ready", 64'(req_ready), 64'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp hold valid", 64'(rsp_valid), 64'b10);
            check("bp hold data", 64'(rsp_data), 64'd1);
            check("bp hold ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp release valid", 64'(rsp_valid), 64'b10);
        tick();
        @(negedge clk);
        check("bp next grant0", 64'(req_ready), 64'b01);
        tick();
        req_valid[0] = 1'b0;
        tick();
        @(negedge clk);
        check("bp req0 rsp", 64'(rsp_valid), 64'b01);
        check("bp req0 data", 64'(rsp_data), 64'd2);
        tick();

        // Fairness: both continuously valid.
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'd0, 32'd100);
        set_req(1, ALU_ADD, 32'd1, 32'd100);
        n_acc = 0;
        for (int k = 0; k < 40 && n_acc < 6; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                acc_idx[n_acc] = req_ready[1] ? 1 : 0;
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            if (n_acc == 6) req_valid = '0;
        end
        req_valid = '0;
        check("fair accept count", 64'(n_acc), 64'd6);
        for (int k = 0; k < n_acc; k++) begin
            check("fair order", 64'(acc_idx[k]), 64'(k % 2));
            if (k > 0) check("fair spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
        end
        repeat (4) tick();

        // Reset while the operation is in EXEC.
        set_req(0, ALU_XOR, 32'hFF, 32'h0F);
        @(negedge clk);
        check("rst-exec grant", 64'(req_ready), 64'b01);
        tick();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("rst-exec rsp", 64'(rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst-exec no rsp", 64'(rsp_valid), 64'd0);
            check("rst-exec alu_a", 64'(alu_a), 64'd0);
            check("rst-exec alu_b", 64'(alu_b), 64'd0);
            check("rst-exec ctl", 64'(alu_ctl), 64'd0);
            check("rst-exec data", 64'(rsp_data), 64'd0);
            tick();
        end
        set_req(0, ALU_XOR, 32'hFF, 32'h0F);
        set_req(1, ALU_ADD, 32'd2, 32'd2);
        @(negedge clk);
        check("rst-exec ptr0", 64'(req_ready), 64'b01);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("rst-exec redo valid", 64'(rsp_valid), 64'b01);
        check("rst-exec redo data", 64'(rsp_data), 64'hF0);
        tick();

        // Randomized traffic against the transaction model.
        do_reset();
        m_ptr = 0;
        m_busy = 1'b0;
        m_owner = 0;
        m_acc = 0;
        m_exp = '0;
        acc = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
                end
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            acc = '0;
            if (!m_busy) begin
                g = rr_pick(m_ptr, req_valid);
                check("rand ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'd0);
                check("rand idle rsp", 64'(rsp_valid), 64'd0);
                if (g >= 0) begin
                    acc[g]  = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = g;
                    m_acc   = cyc;
                    m_exp   = alu_ref(req_a[g*W +: W], req_b[g*W +: W], req_ctl[g*4 +: 4]);
                    m_ptr   = (g + 1) % N;
                end
            end else begin
                check("rand busy ready", 64'(req_ready), 64'd0);
                if (cyc - m_acc < 2) begin
                    check("rand exec rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    check("rand rsp valid", 64'(rsp_valid), 64'(1) << m_owner);
                    check("rand rsp data", 64'(rsp_data), 64'(m_exp));
                    if (rsp_ready[m_owner]) m_busy = 1'b0;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
